ex_mem_pipe_skid: RTL and testbench

- Parametrised successor of the EX/MEM pipeline register.
- Holds ALU result, store data, destination register and a control bundle between EX and MEM.
- Adds a valid/ready handshake, a 2-entry skid buffer so that in_ready is a registered signal, a flush input, and control gating so that bubbles never write memory or registers.
- Sits between the execute stage and the memory stage. The same block is reused for other stage boundaries by changing the parameters.

---
 rtl/ex_mem_pipe_skid_pkg.sv | 24 ++
 rtl/ex_mem_pipe_skid_pipe_entry_reg.sv | 30 +++
 rtl/ex_mem_pipe_skid.sv | 129 ++++++++++++
 tb/tb_ex_mem_pipe_skid.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pipe_skid_pkg.sv
// Shared definitions for the pipeline stage registers: control bundle layout
// and the occupancy state encoding of the skid-buffered stage register.
package ex_mem_pipe_skid_pkg;

    localparam int CTRL_W = 7;

    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_TRUNK_HI = 2;
    localparam int CTRL_TRUNK_LO = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } pipe_state_e;

    function automatic logic stateHasRoom(input pipe_state_e s);
        return (s != FULL);
    endfunction

endpackage

// File: rtl/ex_mem_pipe_skid_pipe_entry_reg.sv
// One storage slot of the stage register: a plain W-bit register with a
// synchronous clear (which wins over load) and an asynchronous reset.
// Updates on the falling edge like the rest of the pipeline.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Slot contents: cleared on reset or clear, otherwise captured on load.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_pipe_skid.sv
// EX/MEM stage register with a valid/ready handshake and a two-entry skid
// buffer, so that in_ready comes straight from a flop. The main entry drives
// the outputs; the skid entry catches the one instruction that arrives while
// MEM is stalling. Flush kills everything held, and control is gated so a
// bubble can never write memory or the register file.
module ex_mem_pipe_skid #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int CTRL_W    = ex_mem_pipe_skid_pkg::CTRL_W,
    parameter int GATE_CTRL = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] registro_2_in,
    input  logic [REG_W-1:0]  reg_dest_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] registro_2_out,
    output logic [REG_W-1:0]  reg_dest_out,
    output logic [CTRL_W-1:0] ctrl_out
);

    import ex_mem_pipe_skid_pkg::*;

    localparam int ENTRY_W = 2 * DATA_W + REG_W + CTRL_W;

    pipe_state_e        state_q, state_d;
    logic               inReady_q;
    logic               accept, drain;
    logic               mainLoad, mainClear, mainFromSkid;
    logic               skidLoad, skidClear;
    logic [ENTRY_W-1:0] inWord, mainWord_d, mainWord_q, skidWord_q;
    logic [CTRL_W-1:0]  mainCtrl;

    assign accept     = in_valid & inReady_q;
    assign drain      = out_valid & out_ready;
    assign inWord     = {result_in, registro_2_in, reg_dest_in, ctrl_in};
    assign mainWord_d = mainFromSkid ? skidWord_q : inWord;

    pipe_entry_reg #(.W(ENTRY_W)) u_main (
        .clock   (clock),
        .reset   (reset),
        .load_i  (mainLoad),
        .clear_i (mainClear),
        .d_i     (mainWord_d),
        .q_o     (mainWord_q)
    );

    pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .load_i  (skidLoad),
        .clear_i (skidClear),
        .d_i     (inWord),
        .q_o     (skidWord_q)
    );

    // Occupancy register; in_ready is precomputed from the next state so MEM-side stalls never reach EX combinationally.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            inReady_q <= stateHasRoom(state_d);
        end
    end

    // Next occupancy and slot load/clear strobes; flush overrides any accept or drain on the same edge.
    always_comb begin
        state_d      = state_q;
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;
        if (flush) begin
            state_d   = EMPTY;
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        mainLoad = 1'b1;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && drain) begin
                        mainLoad = 1'b1;
                    end else if (accept) begin
                        skidLoad = 1'b1;
                        state_d  = FULL;
                    end else if (drain) begin
                        mainClear = 1'b1;
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        mainLoad     = 1'b1;
                        mainFromSkid = 1'b1;
                        skidClear    = 1'b1;
                        state_d      = BUSY;
                    end
                end
                default: begin
                    state_d   = EMPTY;
                    mainClear = 1'b1;
                    skidClear = 1'b1;
                end
            endcase
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = inReady_q;

    assign {result_out, registro_2_out, reg_dest_out, mainCtrl} = mainWord_q;
    assign ctrl_out = ((GATE_CTRL != 0) && !out_valid) ? '0 : mainCtrl;

endmodule

// File: tb/tb_ex_mem_pipe_skid.sv
// Bench for the skid-buffered stage register. A default-width instance and a
// wide instance (64/6/9) share one stimulus stream; the narrow one sees the
// low slices. A queue scoreboard tracks what each instance should be holding.
module tb_ex_mem_pipe_skid;

    logic        clock;
    logic        reset;
    logic        inValid;
    logic        outReady;
    logic        flush;
    logic [63:0] resultIn;
    logic [63:0] reg2In;
    logic [5:0]  regDestIn;
    logic [8:0]  ctrlIn;

    logic        nOutValid, nInReady;
    logic [31:0] nResult, nReg2;
    logic [4:0]  nRegDest;
    logic [6:0]  nCtrl;

    logic        wOutValid, wInReady;
    logic [63:0] wResult, wReg2;
    logic [5:0]  wRegDest;
    logic [8:0]  wCtrl;

    typedef struct {
        logic [63:0] res;
        logic [63:0] r2;
        logic [5:0]  rd;
        logic [8:0]  ctrl;
    } entry_t;

    entry_t sbQ[$];
    int     checks = 0;
    int     errors = 0;

    ex_mem_pipe_skid #(.DATA_W(32), .REG_W(5), .CTRL_W(7), .GATE_CTRL(1)) dutNarrow (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (inValid),
        .in_ready       (nInReady),
        .result_in      (resultIn[31:0]),
        .registro_2_in  (reg2In[31:0]),
        .reg_dest_in    (regDestIn[4:0]),
        .ctrl_in        (ctrlIn[6:0]),
        .flush          (flush),
        .out_valid      (nOutValid),
        .out_ready      (outReady),
        .result_out     (nResult),
        .registro_2_out (nReg2),
        .reg_dest_out   (nRegDest),
        .ctrl_out       (nCtrl)
    );

    ex_mem_pipe_skid #(.DATA_W(64), .REG_W(6), .CTRL_W(9), .GATE_CTRL(1)) dutWide (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (inValid),
        .in_ready       (wInReady),
        .result_in      (resultIn),
        .registro_2_in  (reg2In),
        .reg_dest_in    (regDestIn),
        .ctrl_in        (ctrlIn),
        .flush          (flush),
        .out_valid      (wOutValid),
        .out_ready      (outReady),
        .result_out     (wResult),
        .registro_2_out (wReg2),
        .reg_dest_out   (wRegDest),
        .ctrl_out       (wCtrl)
    );

    // Free-running stage clock; the design acts on the falling edge, the bench samples on the rising edge.
    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic compareAll();
        entry_t e;
        logic   expValid, expReady;
        e.res = '0; e.r2 = '0; e.rd = '0; e.ctrl = '0;
        expValid = (sbQ.size() != 0);
        expReady = (sbQ.size() < 2);
        if (expValid) e = sbQ[0];
        checkOutput("n.out_valid", {63'b0, nOutValid}, {63'b0, expValid});
        checkOutput("n.in_ready",  {63'b0, nInReady},  {63'b0, expReady});
        checkOutput("n.result",    {32'b0, nResult},   {32'b0, e.res[31:0]});
        checkOutput("n.reg2",      {32'b0, nReg2},     {32'b0, e.r2[31:0]});
        checkOutput("n.reg_dest",  {59'b0, nRegDest},  {59'b0, e.rd[4:0]});
        checkOutput("n.ctrl",      {57'b0, nCtrl},     {57'b0, e.ctrl[6:0]});
        checkOutput("w.out_valid", {63'b0, wOutValid}, {63'b0, expValid});
        checkOutput("w.in_ready",  {63'b0, wInReady},  {63'b0, expReady});
        checkOutput("w.result",    wResult,            e.res);
        checkOutput("w.reg2",      wReg2,              e.r2);
        checkOutput("w.reg_dest",  {58'b0, wRegDest},  {58'b0, e.rd});
        checkOutput("w.ctrl",      {55'b0, wCtrl},     {55'b0, e.ctrl});
    endtask

    // Drive one cycle of inputs, advance the scoreboard across the falling edge, then compare on the rising edge.
    task automatic applyStimulus(input logic v, input logic [63:0] res, input logic [63:0] r2,
                                 input logic [5:0] rd, input logic [8:0] ctrl,
                                 input logic ordy, input logic fl);
        entry_t e;
        logic   mAccept, mDrain;
        inValid   = v;
        resultIn  = res;
        reg2In    = r2;
        regDestIn = rd;
        ctrlIn    = ctrl;
        outReady  = ordy;
        flush     = fl;
        mAccept = v && (sbQ.size() < 2) && !fl;
        mDrain  = (sbQ.size() != 0) && ordy;
        @(negedge clock);
        if (fl) begin
            sbQ.delete();
        end else begin
            if (mDrain) void'(sbQ.pop_front());
            if (mAccept) begin
                e.res = res; e.r2 = r2; e.rd = rd; e.ctrl = ctrl;
                sbQ.push_back(e);
            end
        end
        @(posedge clock);
        compareAll();
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'h0, 64'h0, 6'h0, 9'h0, ordy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
        resultIn = '0; reg2In = '0; regDestIn = '0; ctrlIn = '0;
        @(posedge clock);
        compareAll();
        reset = 1'b0;

        // Back-to-back throughput with MEM always ready.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'h8000_0000_0000_0010 + 64'(i), {$urandom, $urandom},
                          6'(6'h20 + i), 9'(9'h100 + i), 1'b1, 1'b0);
        end
        idle(1'b1, 2);

        // Stall: A then B fill both slots, further offers are refused, then drain in order.
        applyStimulus(1'b1, 64'h8000_0000_AAAA_0001, 64'h1234_5678_9ABC_DEF0, 6'h3F, 9'h1FF, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hFFFF_FFFF_BBBB_0002, 64'h8000_0000_0000_0001, 6'h21, 9'h148, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h0000_0000_DEAD_0009, 64'h5, 6'h05, 9'h005, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h0000_0000_DEAD_000A, 64'h6, 6'h06, 9'h006, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Flush while full, with a new instruction offered on the same edge.
        applyStimulus(1'b1, 64'h8000_0000_AAAA_0001, 64'h11, 6'h01, 9'h011, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hFFFF_FFFF_BBBB_0002, 64'h22, 6'h02, 9'h022, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h0000_0000_CCCC_0003, 64'h33, 6'h03, 9'h1FF, 1'b0, 1'b1);
        idle(1'b1, 2);

        // Flush in BUSY while MEM drains on the same edge.
        applyStimulus(1'b1, 64'h0000_0000_4444_0004, 64'h44, 6'h04, 9'h044, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h0000_0000_5555_0005, 64'h55, 6'h05, 9'h055, 1'b1, 1'b1);
        idle(1'b1, 1);

        // Control gating: a MemWrite bundle on idle inputs must never show up.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'h77, 64'h88, 6'h09, 9'h008, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h77, 64'h88, 6'h09, 9'h008, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h77, 64'h88, 6'h09, 9'h008, 1'b1, 1'b0);
        idle(1'b1, 1);

        // Asynchronous reset between edges while full.
        applyStimulus(1'b1, 64'h0000_0000_6666_0006, 64'h66, 6'h06, 9'h066, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h0000_0000_7777_0007, 64'h77, 6'h07, 9'h077, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst.n.out_valid", {63'b0, nOutValid}, 64'h0);
        checkOutput("rst.n.in_ready",  {63'b0, nInReady},  64'h1);
        checkOutput("rst.n.ctrl",      {57'b0, nCtrl},     64'h0);
        checkOutput("rst.w.out_valid", {63'b0, wOutValid}, 64'h0);
        checkOutput("rst.w.in_ready",  {63'b0, wInReady},  64'h1);
        checkOutput("rst.w.result",    wResult,            64'h0);
        sbQ.delete();
        #1 reset = 1'b0;
        idle(1'b1, 1);

        // Mixed random traffic with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                          6'($urandom), 9'($urandom), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 14) == 0));
        end
        idle(1'b1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
